// File: rtl/sha256_pkg.sv
// Shared constants and helpers for the single-block SHA-256 message padder
// and the block buffer it drives.
package sha256_pkg;

    localparam int BLOCK_BYTES     = 32'd64;
    localparam int BLOCK_WORDS     = 32'd16;
    localparam int LEN_FIELD_BYTES = 32'd8;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    // Padder FSM encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_PAD  = 3'd2;
    localparam logic [2:0] ST_EMIT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Message length in bits for a single-block message (at most 55 bytes,
    // so 440 bits fits in 9 bits).
    function automatic logic [8:0] bit_length(input logic [5:0] len_bytes);
        return {len_bytes, 3'b000};
    endfunction

endpackage

// File: rtl/sha256_block_buffer.sv
// 64-byte block register file: whole-block clear, one byte write port,
// a dedicated write of the two low length-field bytes, and a big-endian
// 32-bit word read port.
module sha256_block_buffer
    import sha256_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        len_en,
    input  logic [15:0] len_data,
    input  logic [3:0]  rd_index,
    output logic [31:0] rd_word
);

    logic [7:0] bytes_r [0:BLOCK_BYTES-1];
    logic [5:0] base_s;

    // Byte storage: clear wins over writes; the length bytes (62, 63) never
    // collide with the pad byte because messages are at most 55 bytes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                bytes_r[i] <= 8'h00;
            end
        end else if (clear) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                bytes_r[i] <= 8'h00;
            end
        end else begin
            if (wr_en) begin
                bytes_r[wr_addr] <= wr_data;
            end
            if (len_en) begin
                bytes_r[6'd62] <= len_data[15:8];
                bytes_r[6'd63] <= len_data[7:0];
            end
        end
    end

    // Big-endian word read: byte 4i is the most significant byte.
    always_comb begin
        base_s  = {rd_index, 2'b00};
        rd_word = {bytes_r[base_s],
                   bytes_r[base_s + 6'd1],
                   bytes_r[base_s + 6'd2],
                   bytes_r[base_s + 6'd3]};
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// Single-block SHA-256 message padder. Captures message bytes fetched at the
// read-address counter's address, appends 0x80 and the 64-bit bit length,
// then streams the 512-bit block as 16 big-endian words over valid/ready.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int MAX_MESSAGE_LENGTH = 55,
    parameter int AW                 = $clog2(MAX_MESSAGE_LENGTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] msg_length,
    input  logic [AW-1:0] read_address,
    input  logic          read_complete,
    input  logic [7:0]    msg_data,
    output logic [31:0]   word_out,
    output logic [3:0]    word_index,
    output logic          word_valid,
    input  logic          word_ready,
    output logic          block_done,
    output logic          counter_clear,
    output logic          length_error
);

    localparam logic [AW-1:0] MAX_LEN     = AW'(MAX_MESSAGE_LENGTH);
    localparam logic [AW-1:0] BLOCK_LIMIT = AW'(BLOCK_BYTES);

    logic [2:0]    state_r;
    logic          ld_v_r;
    logic [AW-1:0] ld_a_r;
    logic          word_valid_r;
    logic [3:0]    word_index_r;
    logic          block_done_r;
    logic          counter_clear_r;
    logic          length_error_r;

    logic          buf_clear_s;
    logic          buf_wr_en_s;
    logic [5:0]    buf_wr_addr_s;
    logic [7:0]    buf_wr_data_s;
    logic          buf_len_en_s;
    logic [15:0]   buf_len_data_s;
    logic [31:0]   buf_word_s;

    // Load pipeline: mirrors the one-cycle read latency of message memory so
    // ld_a_r is the address whose data is on msg_data this cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ld_v_r <= 1'b0;
            ld_a_r <= {AW{1'b0}};
        end else begin
            ld_v_r <= start && !read_complete;
            ld_a_r <= read_address;
        end
    end

    // Buffer control decode from the current state.
    always_comb begin
        buf_clear_s    = 1'b0;
        buf_wr_en_s    = 1'b0;
        buf_wr_addr_s  = 6'd0;
        buf_wr_data_s  = 8'h00;
        buf_len_en_s   = 1'b0;
        buf_len_data_s = 16'h0000;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    buf_clear_s = 1'b1;
                end else begin
                    buf_clear_s = 1'b0;
                end
            end
            ST_LOAD: begin
                // Address guard keeps a corrupted counter from aliasing into the block.
                if (ld_v_r && (ld_a_r < BLOCK_LIMIT)) begin
                    buf_wr_en_s   = 1'b1;
                    buf_wr_addr_s = ld_a_r[5:0];
                    buf_wr_data_s = msg_data;
                end else begin
                    buf_wr_en_s   = 1'b0;
                end
            end
            ST_PAD: begin
                buf_wr_en_s    = 1'b1;
                buf_wr_addr_s  = msg_length[5:0];
                buf_wr_data_s  = PAD_BYTE;
                buf_len_en_s   = 1'b1;
                buf_len_data_s = {7'd0, bit_length(msg_length[5:0])};
            end
            default: begin
                buf_clear_s = 1'b0;
            end
        endcase
    end

    // Padder FSM and registered handshake/status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            word_valid_r    <= 1'b0;
            word_index_r    <= 4'd0;
            block_done_r    <= 1'b0;
            counter_clear_r <= 1'b0;
            length_error_r  <= 1'b0;
        end else begin
            block_done_r    <= 1'b0;
            counter_clear_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (msg_length > MAX_LEN) begin
                            // Oversized message: flag it and re-arm the counter.
                            length_error_r  <= 1'b1;
                            counter_clear_r <= 1'b1;
                        end else begin
                            length_error_r  <= 1'b0;
                            state_r         <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    // Leave only once the counter is done and the last fetch landed.
                    if (read_complete && !ld_v_r) begin
                        state_r <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    state_r      <= ST_EMIT;
                    word_valid_r <= 1'b1;
                    word_index_r <= 4'd0;
                end
                ST_EMIT: begin
                    if (word_ready) begin
                        if (word_index_r == 4'd15) begin
                            state_r         <= ST_DONE;
                            word_valid_r    <= 1'b0;
                            block_done_r    <= 1'b1;
                            counter_clear_r <= 1'b1;
                        end else begin
                            word_index_r <= word_index_r + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    word_index_r <= 4'd0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    word_valid_r <= 1'b0;
                    word_index_r <= 4'd0;
                end
            endcase
        end
    end

    sha256_block_buffer u_block_buffer (
        .clock    (clock),
        .reset    (reset),
        .clear    (buf_clear_s),
        .wr_en    (buf_wr_en_s),
        .wr_addr  (buf_wr_addr_s),
        .wr_data  (buf_wr_data_s),
        .len_en   (buf_len_en_s),
        .len_data (buf_len_data_s),
        .rd_index (word_index_r),
        .rd_word  (buf_word_s)
    );

    // Word data is a register-file read at the registered index, forced to
    // zero whenever no word is being offered.
    assign word_out      = word_valid_r ? buf_word_s : 32'h0000_0000;
    assign word_index    = word_index_r;
    assign word_valid    = word_valid_r;
    assign block_done    = block_done_r;
    assign counter_clear = counter_clear_r;
    assign length_error  = length_error_r;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: models the read-address counter and the
// synchronous message memory, queues expected words at stimulus time and
// checks them from an independent monitor.
module tb_sha256_msg_padder;

    localparam int AW = 7;

    logic          clock;
    logic          reset;
    logic          start;
    logic [AW-1:0] msg_length;
    logic [AW-1:0] read_address;
    logic          read_complete;
    logic [7:0]    msg_data;
    logic [31:0]   word_out;
    logic [3:0]    word_index;
    logic          word_valid;
    logic          word_ready;
    logic          block_done;
    logic          counter_clear;
    logic          length_error;

    logic [7:0]  mem [0:63];
    logic [35:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    bit          ready_toggle = 1'b0;

    sha256_msg_padder #(.MAX_MESSAGE_LENGTH(55), .AW(AW)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .msg_length    (msg_length),
        .read_address  (read_address),
        .read_complete (read_complete),
        .msg_data      (msg_data),
        .word_out      (word_out),
        .word_index    (word_index),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .block_done    (block_done),
        .counter_clear (counter_clear),
        .length_error  (length_error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Read-address counter model
    assign read_complete = (read_address == msg_length);
    always @(posedge clock or negedge reset) begin
        if (!reset)                          read_address <= '0;
        else if (counter_clear)              read_address <= '0;
        else if (start && !read_complete)    read_address <= read_address + 7'd1;
    end

    // Synchronous message memory
    always @(posedge clock) msg_data <= mem[read_address[5:0]];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Ready driver: constant 1, or the 1,0,0,1 pattern while a word is offered.
    initial begin
        int k;
        logic [3:0] pat;
        k = 0;
        pat = 4'b1001;
        word_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (ready_toggle) begin
                if (word_valid) begin
                    word_ready = pat[3 - (k % 4)];
                    k++;
                end
            end else begin
                word_ready = 1'b1;
                k = 0;
            end
        end
    end

    // Monitor: pops expected words on handshakes, checks hold during stalls
    // and the block_done pulse after word 15.
    initial begin
        bit          held;
        bit          done_pending;
        logic [35:0] held_v;
        logic [35:0] e;
        held = 1'b0;
        done_pending = 1'b0;
        held_v = '0;
        forever begin
            @(negedge clock);
            if (done_pending) begin
                check("block_done_pulse", {63'd0, block_done}, 64'd1);
                done_pending = 1'b0;
            end
            if (word_valid) begin
                if (held) check("hold_stable", {28'd0, word_index, word_out}, {28'd0, held_v});
                if (word_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", {28'd0, word_index, word_out}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", {28'd0, word_index, word_out}, {28'd0, e});
                        if (word_index == 4'd15) done_pending = 1'b1;
                    end
                end else begin
                    held = 1'b1;
                    held_v = {word_index, word_out};
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic push_abc();
        exp_q.push_back({4'd0, 32'h6162_6380});
        for (int i = 1; i < 15; i++) exp_q.push_back({i[3:0], 32'h0});
        exp_q.push_back({4'd15, 32'h0000_0018});
    endtask

    task automatic push_model(input int len);
        logic [7:0]  blk [0:63];
        logic [15:0] bl;
        for (int i = 0; i < 64; i++) blk[i] = (i < len) ? mem[i] : 8'h00;
        blk[len] = 8'h80;
        bl = 16'(len * 8);
        blk[62] = bl[15:8];
        blk[63] = bl[7:0];
        for (int w = 0; w < 16; w++)
            exp_q.push_back({w[3:0], blk[4*w], blk[4*w+1], blk[4*w+2], blk[4*w+3]});
    endtask

    task automatic load_abc();
        for (int i = 0; i < 64; i++) mem[i] = 8'hEE;
        mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;
    endtask

    task automatic run_msg(input int len, input bit stall);
        int n;
        @(posedge clock); #1;
        msg_length = 7'(len);
        start = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check("length_error_cleared", {63'd0, length_error}, 64'd0);
        if (stall) begin
            n = 0;
            while (read_address < 7'd4 && n < 200) begin @(posedge clock); #1; n++; end
            start = 1'b0;
            repeat (3) @(posedge clock);
            #1 start = 1'b1;
        end
        n = 0;
        while (!read_complete && n < 200) begin @(negedge clock); n++; end
        start = 1'b0;
        n = 0;
        while (!block_done && n < 300) begin @(negedge clock); n++; end
        check("block_done_seen", {63'd0, block_done}, 64'd1);
        check("all_words_emitted", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;
        msg_length = '0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_word_out", {32'd0, word_out}, 64'd0);
        check("rst_word_index", {60'd0, word_index}, 64'd0);
        check("rst_word_valid", {63'd0, word_valid}, 64'd0);
        check("rst_block_done", {63'd0, block_done}, 64'd0);
        check("rst_counter_clear", {63'd0, counter_clear}, 64'd0);
        check("rst_length_error", {63'd0, length_error}, 64'd0);
        @(posedge clock); #1 reset = 1'b1;

        // "abc"
        load_abc();
        push_abc();
        run_msg(3, 1'b0);

        // empty message
        exp_q.push_back({4'd0, 32'h8000_0000});
        for (int i = 1; i < 16; i++) exp_q.push_back({i[3:0], 32'h0});
        run_msg(0, 1'b0);

        // largest message, bytes 0x00..0x36
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        push_model(55);
        check("len55_word13_model", {28'd0, exp_q[13]}, {28'd0, 4'd13, 32'h3435_3680});
        check("len55_word15_model", {28'd0, exp_q[15]}, {28'd0, 4'd15, 32'h0000_01B8});
        run_msg(55, 1'b0);

        // oversized message
        @(posedge clock); #1;
        msg_length = 7'd56;
        start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
        @(negedge clock);
        check("err_length_error", {63'd0, length_error}, 64'd1);
        check("err_counter_clear", {63'd0, counter_clear}, 64'd1);
        @(negedge clock);
        check("err_clear_one_cycle", {63'd0, counter_clear}, 64'd0);
        check("err_sticky", {63'd0, length_error}, 64'd1);
        n = 0;
        repeat (5) begin @(negedge clock); if (word_valid) n++; end
        check("err_no_valid", 64'(n), 64'd0);
        load_abc();
        push_abc();
        run_msg(3, 1'b0);

        // "abc" with backpressure
        ready_toggle = 1'b1;
        push_abc();
        run_msg(3, 1'b0);
        ready_toggle = 1'b0;

        // 10-byte message with a mid-load start stall
        for (int i = 0; i < 64; i++) mem[i] = 8'hA0 + 8'(i);
        push_model(10);
        run_msg(10, 1'b1);

        // reset during EMIT at index 5
        load_abc();
        push_abc();
        @(posedge clock); #1;
        msg_length = 7'd3;
        start = 1'b1;
        @(posedge clock); #1;
        n = 0;
        while (!read_complete && n < 200) begin @(posedge clock); #1; n++; end
        start = 1'b0;
        n = 0;
        while (!(word_valid && word_index == 4'd5) && n < 200) begin @(posedge clock); #1; n++; end
        check("reached_index5", {63'd0, word_valid}, 64'd1);
        #1 reset = 1'b0;
        #1;
        check("midrst_word_out", {32'd0, word_out}, 64'd0);
        check("midrst_word_index", {60'd0, word_index}, 64'd0);
        check("midrst_word_valid", {63'd0, word_valid}, 64'd0);
        check("midrst_block_done", {63'd0, block_done}, 64'd0);
        check("midrst_counter_clear", {63'd0, counter_clear}, 64'd0);
        check("midrst_length_error", {63'd0, length_error}, 64'd0);
        exp_q.delete();
        @(posedge clock); #1 reset = 1'b1;

        // recovery after reset
        push_abc();
        run_msg(3, 1'b0);

        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
